// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter slice.
// State encoding, width helper and parameter defaults live here.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int DW_DEF           = 8;
  localparam int BUSY_TIMEOUT_DEF = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set req at or after ptr,
// wrapping modulo NREQ.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);

  int            j;
  logic [IW-1:0] jw;

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    j      = 0;
    jw     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j  = (int'(ptr) + i) % NREQ;
      jw = IW'(j);
      if (req[jw]) begin
        valid      = 1'b1;
        onehot     = '0;
        onehot[jw] = 1'b1;
        idx        = jw;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ
// requesters; tracks tx_busy per frame and pulses done per requester.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DW           = DW_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 tx_err,
  output logic                 arb_busy,
  output logic                 tx_start,
  output logic [DW-1:0]        tx_data_in,
  input  logic                 tx_busy
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic            abusy_q, abusy_d;
  logic [DW-1:0]   data_q, data_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;

  logic            pick_valid;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;

  uart_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    start_d = 1'b0;
    data_d  = data_q;
    ptr_d   = ptr_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid && !tx_busy) begin
          gnt_d   = pick_oh;
          data_d  = req_data[pick_idx*DW +: DW];
          k_d     = pick_idx;
          start_d = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else begin
          cnt_d = cnt_inc;
          // Transmitter never acknowledged the start: abort the frame.
          if (cnt_inc >= CNT_LAST) begin
            err_d   = 1'b1;
            done_d  = gnt_q;
            state_d = ST_DONE;
          end
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          done_d  = gnt_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        ptr_d   = (k_q == IDX_LAST) ? '0 : k_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    abusy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      abusy_q <= 1'b0;
      data_q  <= '0;
      ptr_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      abusy_q <= abusy_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign tx_err     = err_q;
  assign tx_start   = start_q;
  assign arb_busy   = abusy_q;
  assign tx_data_in = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus hand-written
// contention, timeout and mid-frame reset sequences.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        tx_err;
  logic        arb_busy;
  logic        tx_start;
  logic [7:0]  tx_data_in;
  logic        tx_busy;

  int nvec;
  int nfail;

  uart_tx_arbiter dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .done       (done),
    .tx_err     (tx_err),
    .arb_busy   (arb_busy),
    .tx_start   (tx_start),
    .tx_data_in (tx_data_in),
    .tx_busy    (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] req;
    logic       busy;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       st;
    logic       err;
    logic       ab;
    logic [7:0] dat;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic b,
                              input logic [3:0] g, input logic [3:0] d,
                              input logic s, input logic e,
                              input logic a, input logic [7:0] x);
    vec_t v;
    v.req = r; v.busy = b; v.gnt = g; v.done = d;
    v.st = s; v.err = e; v.ab = a; v.dat = x;
    return v;
  endfunction

  logic [3:0] exp_oh[5];
  int starts, dones, bcnt, n;
  logic ovl, found, got, dseen;

  initial begin
    nvec  = 0;
    nfail = 0;
    // byte3=7E, byte2=55, byte1=A5, byte0=C3
    req_data = 32'h7E55A5C3;
    req      = '0;
    tx_busy  = 1'b0;
    rstn     = 1'b0;

    // single request, busy gating, withdrawal, ptr wrap
    vt[0]  = mk(4'b0010, 0, 4'b0010, 4'b0000, 1, 0, 1, 8'hA5);
    vt[1]  = mk(4'b0010, 0, 4'b0010, 4'b0000, 0, 0, 1, 8'hA5);
    vt[2]  = mk(4'b0010, 1, 4'b0010, 4'b0000, 0, 0, 1, 8'hA5);
    vt[3]  = mk(4'b0000, 1, 4'b0010, 4'b0000, 0, 0, 1, 8'hA5);
    vt[4]  = mk(4'b0000, 0, 4'b0010, 4'b0010, 0, 0, 1, 8'hA5);
    vt[5]  = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 8'hA5);
    vt[6]  = mk(4'b0001, 1, 4'b0000, 4'b0000, 0, 0, 0, 8'hA5);
    vt[7]  = mk(4'b0001, 1, 4'b0000, 4'b0000, 0, 0, 0, 8'hA5);
    vt[8]  = mk(4'b0001, 0, 4'b0001, 4'b0000, 1, 0, 1, 8'hC3);
    vt[9]  = mk(4'b0001, 1, 4'b0001, 4'b0000, 0, 0, 1, 8'hC3);
    vt[10] = mk(4'b0001, 1, 4'b0001, 4'b0000, 0, 0, 1, 8'hC3);
    vt[11] = mk(4'b0000, 0, 4'b0001, 4'b0001, 0, 0, 1, 8'hC3);
    vt[12] = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 8'hC3);
    vt[13] = mk(4'b0100, 1, 4'b0000, 4'b0000, 0, 0, 0, 8'hC3);
    vt[14] = mk(4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 8'hC3);
    vt[15] = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 8'hC3);
    vt[16] = mk(4'b1000, 0, 4'b1000, 4'b0000, 1, 0, 1, 8'h7E);
    vt[17] = mk(4'b1000, 0, 4'b1000, 4'b0000, 0, 0, 1, 8'h7E);
    vt[18] = mk(4'b1000, 1, 4'b1000, 4'b0000, 0, 0, 1, 8'h7E);
    vt[19] = mk(4'b0000, 0, 4'b1000, 4'b1000, 0, 0, 1, 8'h7E);
    vt[20] = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 8'h7E);

    exp_oh[0] = 4'b0001;
    exp_oh[1] = 4'b0010;
    exp_oh[2] = 4'b0100;
    exp_oh[3] = 4'b1000;
    exp_oh[4] = 4'b0001;

    #3;
    chk("reset_outs", {gnt, done, tx_start, tx_err, arb_busy, tx_data_in},
        '0);
    #19 rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      req     = vt[i].req;
      tx_busy = vt[i].busy;
      @(posedge clk); #1;
      chk($sformatf("v%0d_gnt", i), gnt, vt[i].gnt);
      chk($sformatf("v%0d_done", i), done, vt[i].done);
      chk($sformatf("v%0d_start", i), tx_start, vt[i].st);
      chk($sformatf("v%0d_err", i), tx_err, vt[i].err);
      chk($sformatf("v%0d_abusy", i), arb_busy, vt[i].ab);
      chk($sformatf("v%0d_data", i), tx_data_in, vt[i].dat);
    end

    // contention: all four held, ptr starts at 0
    req = 4'hF; tx_busy = 1'b0;
    starts = 0; dones = 0; bcnt = 0; ovl = 1'b0;
    for (int c = 0; c < 300 && dones < 5; c++) begin
      @(posedge clk); #1;
      if ((gnt & (gnt - 4'd1)) != 0 || (done & (done - 4'd1)) != 0)
        ovl = 1'b1;
      if (tx_start) begin
        if (starts != dones) ovl = 1'b1;
        if (starts < 5)
          chk($sformatf("rr_gnt%0d", starts), gnt, exp_oh[starts]);
        starts++;
        bcnt = 3;
      end
      if (done != 0) begin
        chk($sformatf("rr_done%0d", dones), done, gnt);
        dones++;
      end
      if (bcnt > 0) begin
        tx_busy = 1'b1;
        bcnt--;
      end else begin
        tx_busy = 1'b0;
      end
    end
    req = '0;
    chk("rr_dones", dones, 5);
    chk("rr_starts", starts, 5);
    chk("rr_onehot", ovl, 0);

    // timeout: tx_busy never rises, ptr is now 1
    @(posedge clk); #1;
    req = 4'b0100; tx_busy = 1'b0; found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk); #1;
      if (tx_start) found = 1'b1;
    end
    chk("to_start", found, 1);
    chk("to_gnt", gnt, 4'b0100);
    n = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      n++;
      if (done != 0) got = 1'b1;
    end
    chk("to_latency", n, 16);
    chk("to_err", tx_err, 1);
    chk("to_done", done, 4'b0100);
    req = 4'hF;
    @(posedge clk); #1;
    chk("to_idle_gnt", gnt, 0);
    chk("to_err_clr", tx_err, 0);
    @(posedge clk); #1;
    chk("to_next_ptr", gnt, 4'b1000);
    chk("to_next_start", tx_start, 1);

    // reset while in WAIT_LO
    tx_busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_abusy", arb_busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async", {gnt, done, tx_start, tx_err, arb_busy, tx_data_in},
        '0);
    req = 4'b1001; tx_busy = 1'b0; dseen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done != 0 || gnt != 0) dseen = 1'b1;
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_done", dseen, 0);
    chk("rst_ptr0_gnt", gnt, 4'b0001);
    chk("rst_ptr0_data", tx_data_in, 8'hC3);
    chk("rst_ptr0_start", tx_start, 1);

    req = '0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      if (!arb_busy) got = 1'b1;
    end
    chk("final_idle", got, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
